// File: rtl/pmem_icache.sv
`default_nettype none
// ============================================================================
// Module   : pmem_icache
// Brief    : Direct-mapped, tagged, read-only instruction cache that serves
//            N fetchers round-robin through one lookup/fill engine.
// Revision : 1.0 - initial release
// ============================================================================
module pmem_icache #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 2,
    parameter int NUM_LINES     = 16,
    parameter int COUNT_BITS    = 16
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    output logic                                     mem_read_valid,
    output logic [ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                     mem_read_ready,
    input  logic [DATA_BITS-1:0]                     mem_read_data,
    input  logic                                     invalidate,
    output logic [COUNT_BITS-1:0]                    hit_count,
    output logic [COUNT_BITS-1:0]                    miss_count
);

    localparam int INDEX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;
    localparam int GW         = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2
    } state_t;

    state_t                                  state_q;
    logic [GW-1:0]                           grant_q;
    logic [GW-1:0]                           last_grant_q;
    logic [ADDR_BITS-1:0]                    addr_q;
    logic                                    drop_q;
    logic                                    mem_valid_q;
    logic [ADDR_BITS-1:0]                    mem_addr_q;
    logic [NUM_CONSUMERS-1:0]                ready_q;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] data_q;
    logic [COUNT_BITS-1:0]                   hit_q;
    logic [COUNT_BITS-1:0]                   miss_q;
    logic [NUM_LINES-1:0]                    line_valid_q;
    logic [TAG_BITS-1:0]                     line_tag_q  [NUM_LINES];
    logic [DATA_BITS-1:0]                    line_data_q [NUM_LINES];

    logic [NUM_CONSUMERS-1:0] eligible_d;
    logic [GW-1:0]            grant_d;
    logic [GW-1:0]            cand_d;
    logic                     grant_found_d;
    logic [INDEX_BITS-1:0]    idx_d;
    logic [TAG_BITS-1:0]      tag_d;
    logic                     hit_d;
    logic                     install_d;

    assign eligible_d = consumer_read_valid & ~ready_q;
    assign idx_d      = addr_q[INDEX_BITS-1:0];
    assign tag_d      = addr_q[ADDR_BITS-1:INDEX_BITS];
    assign hit_d      = line_valid_q[idx_d] && (line_tag_q[idx_d] == tag_d) && !invalidate;
    assign install_d  = (state_q == ST_FILL) && mem_read_ready && !drop_q && !invalidate;

    // Round-robin: first eligible consumer after the previous grant.
    always_comb begin
        grant_found_d = 1'b0;
        grant_d       = '0;
        cand_d        = '0;
        for (int i = 1; i <= NUM_CONSUMERS; i++) begin
            cand_d = GW'((int'(last_grant_q) + i) % NUM_CONSUMERS);
            if (!grant_found_d && eligible_d[cand_d]) begin
                grant_found_d = 1'b1;
                grant_d       = cand_d;
            end
        end
    end

    // Tag/data storage needs no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (install_d) begin
            line_tag_q[idx_d]  <= tag_d;
            line_data_q[idx_d] <= mem_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= '0;
            addr_q       <= '0;
            drop_q       <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            ready_q      <= '0;
            data_q       <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
            line_valid_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                if (ready_q[c] && !consumer_read_valid[c]) begin
                    ready_q[c] <= 1'b0;
                    data_q[c]  <= '0;
                end
            end

            if (invalidate) begin
                line_valid_q <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (grant_found_d) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        addr_q       <= consumer_read_address[grant_d];
                        state_q      <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit_d) begin
                        ready_q[grant_q] <= 1'b1;
                        data_q[grant_q]  <= line_data_q[idx_d];
                        if (hit_q != {COUNT_BITS{1'b1}}) begin
                            hit_q <= hit_q + 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end else begin
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= addr_q;
                        if (miss_q != {COUNT_BITS{1'b1}}) begin
                            miss_q <= miss_q + 1'b1;
                        end
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (invalidate) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_read_ready) begin
                        mem_valid_q      <= 1'b0;
                        ready_q[grant_q] <= 1'b1;
                        data_q[grant_q]  <= mem_read_data;
                        if (install_d) begin
                            line_valid_q[idx_d] <= 1'b1;
                        end
                        drop_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign consumer_read_ready = ready_q;
    assign consumer_read_data  = data_q;
    assign mem_read_valid      = mem_valid_q;
    assign mem_read_address    = mem_addr_q;
    assign hit_count           = hit_q;
    assign miss_count          = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_pmem_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_icache
// Brief    : Directed self-checking bench for pmem_icache (16 lines, 4-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_icache;

    logic             clk;
    logic             reset;
    logic [1:0]       cr_valid;
    logic [1:0][7:0]  cr_addr;
    logic [1:0]       cr_ready;
    logic [1:0][15:0] cr_data;
    logic             mem_read_valid;
    logic [7:0]       mem_read_address;
    logic             mem_read_ready;
    logic [15:0]      mem_read_data;
    logic             invalidate;
    logic [3:0]       hit_count;
    logic [3:0]       miss_count;

    int n_cmp;
    int n_err;

    pmem_icache #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(2), .NUM_LINES(16), .COUNT_BITS(4)
    ) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(cr_valid), .consumer_read_address(cr_addr),
        .consumer_read_ready(cr_ready), .consumer_read_data(cr_data),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .invalidate(invalidate), .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cr_valid = '0; cr_addr = '0;
        mem_read_ready = 1'b0; mem_read_data = '0; invalidate = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One access by consumer c; memory answers after 3 cycles of mem_read_valid.
    // inv_mode: 0 none, 1 pulse in FILL, 2 with fill completion, 3 pulse in LOOKUP.
    // edges = negedges from valid until ready seen (0 = never).
    task automatic access(input int c, input logic [7:0] a, input logic [15:0] md,
                          input int inv_mode, output int edges, output int nreq,
                          output logic [7:0] raddr, output logic [15:0] rdata);
        logic prev_mv;
        int   mvc;
        edges = 0; nreq = 0; raddr = '0; rdata = '0; prev_mv = 1'b0; mvc = 0;
        cr_valid[c] = 1'b1;
        cr_addr[c]  = a;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            invalidate = 1'b0;
            if (cr_ready[c]) begin
                edges = k;
                rdata = cr_data[c];
                break;
            end
            if (inv_mode == 3 && k == 1) invalidate = 1'b1;
            if (mem_read_valid && !prev_mv) begin
                nreq++;
                raddr = mem_read_address;
                if (inv_mode == 1) invalidate = 1'b1;
            end
            prev_mv = mem_read_valid;
            if (mem_read_valid) begin
                mvc++;
                if (mvc == 3) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = md;
                    if (inv_mode == 2) invalidate = 1'b1;
                end
            end
        end
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        invalidate     = 1'b0;
        cr_valid[c]    = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (cr_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", cr_ready); end
        n_cmp++; if (cr_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", cr_data); end
        n_cmp++; if (mem_read_valid !== 1'b0 || mem_read_address !== 8'h00) begin
            n_err++; $display("FAIL reset_mem got v=%b a=%h want v=0 a=00", mem_read_valid, mem_read_address); end
        n_cmp++; if (hit_count !== 4'd0 || miss_count !== 4'd0) begin
            n_err++; $display("FAIL reset_counts got h=%0d m=%0d want 0/0", hit_count, miss_count); end
    endtask

    task automatic test_cold_miss_then_hit();
        int e, n; logic [7:0] ra; logic [15:0] rd;
        do_reset();
        access(0, 8'h23, 16'hBEEF, 0, e, n, ra, rd);
        n_cmp++; if (n !== 1 || ra !== 8'h23) begin n_err++; $display("FAIL cold_memreq got n=%0d a=%h want 1/23", n, ra); end
        n_cmp++; if (rd !== 16'hBEEF || e !== 5) begin n_err++; $display("FAIL cold_data got %h at %0d want BEEF at 5", rd, e); end
        n_cmp++; if (miss_count !== 4'd1) begin n_err++; $display("FAIL cold_miss_cnt got %0d want 1", miss_count); end
        n_cmp++; if (cr_ready[0] !== 1'b0 || cr_data[0] !== 16'h0) begin
            n_err++; $display("FAIL release got r=%b d=%h want 0/0", cr_ready[0], cr_data[0]); end
        access(0, 8'h23, 16'h1111, 0, e, n, ra, rd);
        n_cmp++; if (e !== 2 || n !== 0) begin n_err++; $display("FAIL hit_latency got e=%0d n=%0d want 2/0", e, n); end
        n_cmp++; if (rd !== 16'hBEEF || hit_count !== 4'd1) begin
            n_err++; $display("FAIL hit_data got %h h=%0d want BEEF/1", rd, hit_count); end
    endtask

    task automatic test_conflict_eviction();
        int e, n; logic [7:0] ra; logic [15:0] rd;
        do_reset();
        access(0, 8'h05, 16'hA005, 0, e, n, ra, rd);
        access(0, 8'h15, 16'hA015, 0, e, n, ra, rd);
        access(0, 8'h15, 16'h0000, 0, e, n, ra, rd);
        n_cmp++; if (n !== 0 || rd !== 16'hA015) begin n_err++; $display("FAIL evict_resident got n=%0d d=%h want 0/A015", n, rd); end
        access(0, 8'h05, 16'hB005, 0, e, n, ra, rd);
        n_cmp++; if (n !== 1 || rd !== 16'hB005 || miss_count !== 4'd3) begin
            n_err++; $display("FAIL evict_miss got n=%0d d=%h m=%0d want 1/B005/3", n, rd, miss_count); end
        access(0, 8'h15, 16'hC015, 0, e, n, ra, rd);
        n_cmp++; if (n !== 1 || rd !== 16'hC015) begin n_err++; $display("FAIL evict_victim got n=%0d d=%h want 1/C015", n, rd); end
    endtask

    task automatic test_round_robin();
        int e, n; logic [7:0] ra; logic [15:0] rd;
        int t0, t1; logic [15:0] d0, d1;
        do_reset();
        access(0, 8'h30, 16'hC030, 0, e, n, ra, rd);
        access(1, 8'h31, 16'hC131, 0, e, n, ra, rd);
        for (int r = 0; r < 2; r++) begin
            if (r == 1) access(0, 8'h30, 16'h0, 0, e, n, ra, rd);
            t0 = 0; t1 = 0; d0 = '0; d1 = '0;
            cr_valid = 2'b11; cr_addr[0] = 8'h30; cr_addr[1] = 8'h31;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (cr_ready[0] && t0 == 0) begin t0 = k; d0 = cr_data[0]; end
                if (cr_ready[1] && t1 == 0) begin t1 = k; d1 = cr_data[1]; end
                if (t0 != 0 && t1 != 0) break;
            end
            cr_valid = 2'b00;
            @(negedge clk);
            if (r == 0) begin
                n_cmp++; if (t0 !== 2 || t1 !== 4) begin n_err++; $display("FAIL rr_first got t0=%0d t1=%0d want 2/4", t0, t1); end
            end else begin
                n_cmp++; if (t1 !== 2 || t0 !== 4) begin n_err++; $display("FAIL rr_second got t0=%0d t1=%0d want 4/2", t0, t1); end
            end
            n_cmp++; if (d0 !== 16'hC030 || d1 !== 16'hC131) begin
                n_err++; $display("FAIL rr_data got %h/%h want C030/C131", d0, d1); end
        end
        n_cmp++; if (hit_count !== 4'd5 || miss_count !== 4'd2) begin
            n_err++; $display("FAIL rr_counts got h=%0d m=%0d want 5/2", hit_count, miss_count); end
    endtask

    task automatic test_invalidate();
        int e, n; logic [7:0] ra; logic [15:0] rd;
        do_reset();
        access(0, 8'h12, 16'hD012, 0, e, n, ra, rd);
        access(0, 8'h40, 16'hE040, 1, e, n, ra, rd);
        n_cmp++; if (rd !== 16'hE040 || e !== 5) begin n_err++; $display("FAIL inv_fill_data got %h at %0d want E040 at 5", rd, e); end
        access(0, 8'h40, 16'hE140, 0, e, n, ra, rd);
        n_cmp++; if (n !== 1 || rd !== 16'hE140) begin n_err++; $display("FAIL inv_fill_dropped got n=%0d d=%h want 1/E140", n, rd); end
        access(0, 8'h12, 16'hD112, 0, e, n, ra, rd);
        n_cmp++; if (n !== 1 || rd !== 16'hD112) begin n_err++; $display("FAIL inv_old_line got n=%0d d=%h want 1/D112", n, rd); end
        access(0, 8'h50, 16'hF050, 2, e, n, ra, rd);
        n_cmp++; if (rd !== 16'hF050) begin n_err++; $display("FAIL inv_done_data got %h want F050", rd); end
        access(0, 8'h50, 16'hF150, 0, e, n, ra, rd);
        n_cmp++; if (n !== 1 || rd !== 16'hF150) begin n_err++; $display("FAIL inv_done_dropped got n=%0d d=%h want 1/F150", n, rd); end
        access(0, 8'h50, 16'h0000, 3, e, n, ra, rd);
        n_cmp++; if (n !== 1 || rd !== 16'h0000) begin n_err++; $display("FAIL inv_lookup got n=%0d d=%h want 1/0000", n, rd); end
        n_cmp++; if (miss_count !== 4'd7 || hit_count !== 4'd0) begin
            n_err++; $display("FAIL inv_counts got h=%0d m=%0d want 0/7", hit_count, miss_count); end
    endtask

    task automatic test_counter_saturation();
        int e, n; logic [7:0] ra; logic [15:0] rd;
        do_reset();
        access(1, 8'h07, 16'h7007, 0, e, n, ra, rd);
        for (int i = 0; i < 20; i++) begin
            access(1, 8'h07, 16'h0, 0, e, n, ra, rd);
            if (i == 14) begin
                n_cmp++; if (hit_count !== 4'd15) begin n_err++; $display("FAIL sat_reach got %0d want 15", hit_count); end
            end
        end
        n_cmp++; if (hit_count !== 4'd15 || miss_count !== 4'd1) begin
            n_err++; $display("FAIL sat_hold got h=%0d m=%0d want 15/1", hit_count, miss_count); end
    endtask

    task automatic test_reset_mid_fill();
        int e, n, waited; logic [7:0] ra; logic [15:0] rd;
        do_reset();
        access(0, 8'h61, 16'h6161, 0, e, n, ra, rd);
        cr_valid[0] = 1'b1; cr_addr[0] = 8'h60;
        waited = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_read_valid) begin waited = k; break; end
        end
        n_cmp++; if (waited !== 2) begin n_err++; $display("FAIL midfill_req got %0d want 2", waited); end
        reset = 1'b1; cr_valid = '0;
        @(negedge clk);
        n_cmp++; if (mem_read_valid !== 1'b0 || cr_ready !== 2'b00 || miss_count !== 4'd0) begin
            n_err++; $display("FAIL midfill_reset got v=%b r=%b m=%0d want 0/00/0", mem_read_valid, cr_ready, miss_count); end
        reset = 1'b0;
        mem_read_ready = 1'b1; mem_read_data = 16'h9999;
        @(negedge clk);
        mem_read_ready = 1'b0; mem_read_data = '0;
        @(negedge clk);
        n_cmp++; if (cr_ready !== 2'b00 || cr_data !== '0 || mem_read_valid !== 1'b0) begin
            n_err++; $display("FAIL late_resp got r=%b d=%h v=%b want 00/0/0", cr_ready, cr_data, mem_read_valid); end
        access(0, 8'h60, 16'h6060, 0, e, n, ra, rd);
        n_cmp++; if (n !== 1 || rd !== 16'h6060 || miss_count !== 4'd1) begin
            n_err++; $display("FAIL post_reset got n=%0d d=%h m=%0d want 1/6060/1", n, rd, miss_count); end
        access(0, 8'h61, 16'h6262, 0, e, n, ra, rd);
        n_cmp++; if (n !== 1 || rd !== 16'h6262) begin n_err++; $display("FAIL post_reset_old got n=%0d d=%h want 1/6262", n, rd); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1; cr_valid = '0; cr_addr = '0;
        mem_read_ready = 1'b0; mem_read_data = '0; invalidate = 1'b0;
        test_reset();
        test_cold_miss_then_hit();
        test_conflict_eviction();
        test_round_robin();
        test_invalidate();
        test_counter_saturation();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
